sram_arbiter: RTL and testbench
===============================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter: READ_LATENCY, 2, cycles from read address on SRAM_address to valid SRAM_read_data.
REQ-002 Clock  in  1  system clock; all state updates on rising edge.
REQ-003 Resetn  in  1  reset, asynchronous, active-low.
REQ-004 R0_req / R1_req  in  1 each  requester wants ownership of SRAM; held high for the whole burst.
REQ-005 R0_address / R1_address  in  18 each  access address.
REQ-006 R0_write_data / R1_write_data  in  16 each  write data.
REQ-007 R0_we_n / R1_we_n  in  1 each  0 = write, 1 = read.
REQ-008 R0_gnt / R1_gnt  out  1 each  port owns SRAM this cycle.
REQ-009 R0_rvalid / R1_rvalid  out  1 each  Read_data holds this port's read result.
REQ-010 SRAM_address  out  18; SRAM_write_data  out  16; SRAM_we_n  out  1: shared SRAM port.
REQ-011 SRAM_read_data  in  16  SRAM read data; Read_data  out  16  broadcast copy to both ports.
REQ-012 Busy  out  1  high while owned, in turnaround, or any read is in flight.

Function
REQ-013 State machine SHALL have exactly S_IDLE, S_OWN0, S_OWN1 and S_TURN.
REQ-014 S_IDLE: exactly one req high -> go to the matching S_OWNx; both high -> go to the port not equal to last_owner; none -> stay.
REQ-015 last_owner SHALL be 1 after reset, so port 0 wins the first tie.
REQ-016 Grant latency SHALL be 1 cycle: req sampled high in S_IDLE at edge k -> Rx_gnt high after edge k.
REQ-017 Rx_gnt SHALL be high exactly while state is S_OWNx, and R0_gnt & R1_gnt SHALL never both be high.
REQ-018 In S_OWNx: SRAM_address = Rx_address and SRAM_write_data = Rx_write_data combinationally; SRAM_we_n = Rx_we_n | ~Rx_req.
REQ-019 In S_OWNx, Rx_req sampled low -> go to S_TURN and set last_owner <= x; the other port's req SHALL NOT preempt the owner.
REQ-020 S_TURN: lasts one cycle, then always goes to S_IDLE.
REQ-021 In S_IDLE and S_TURN: SRAM_we_n = 1, SRAM_address = 0, SRAM_write_data = 0.
REQ-022 A read access is a cycle in S_OWNx with Rx_req = 1 and Rx_we_n = 1.
REQ-023 Each read access SHALL enter a READ_LATENCY-deep shift pipeline of {valid, port} entries; pipeline advances every cycle, independent of state.
REQ-024 Rx_rvalid SHALL equal (pipeline output valid & output port == x); Read_data = SRAM_read_data, unregistered.
REQ-025 Reads issued in the last owned cycle SHALL still return, with correct tag, during S_TURN, S_IDLE or the next owner's cycles.
REQ-026 At most one rvalid SHALL be high per cycle.
REQ-027 Busy = (state != S_IDLE) | any pipeline entry valid.
REQ-028 The arbiter SHALL NOT bound hold time: an owner that keeps req high starves the other port indefinitely.

Reset
REQ-029 Resetn low, at any time including mid-burst, SHALL immediately force all of the following:
- state = S_IDLE, last_owner = 1, all pipeline entries invalid;
- both gnt = 0 and both rvalid = 0;
- SRAM_we_n = 1, SRAM_address = 0, SRAM_write_data = 0, Busy = 0.
REQ-030 Reads in flight at reset SHALL be discarded and never signalled.

Verification
REQ-031 Reset check: Resetn low -> gnt = 00, rvalid = 00, SRAM_we_n = 1, SRAM_address = 0, Busy = 0.
REQ-032 Write then read:
- R0_req rises before edge k -> R0_gnt high after edge k.
- Write addr 0x00005, data 0xABCD -> SRAM_we_n = 0 in the same cycle.
- Read addr 0x00005 issued in cycle t -> R0_rvalid high in cycle t+2 with Read_data = 0xABCD.
REQ-033 Tie and handover:
- R0_req and R1_req rise together after reset -> R0 is granted.
- R0_req drops -> one S_TURN cycle with SRAM_we_n = 1, then S_IDLE.
- R1_gnt rises after the 3rd edge following the R0_req drop.
REQ-034 Round-robin: after R1 releases, with both requesting -> R0 is granted next.
REQ-035 Tail read: R1 reads addr 0x3FFFF in its last owned cycle, then drops req -> R1_rvalid high 2 cycles later, R0_rvalid stays 0, Busy stays high until then.
REQ-036 Reset mid-burst: Resetn pulsed low with an R1 read in flight -> R1_rvalid never asserts; R1_gnt = 0 until a new request.

Source files
------------

// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: the requester ports and the shared SRAM port of the
// two-port SRAM arbiter, grouped into one bundle.
// The master side is the environment: both requesters plus the SRAM device.
// The slave side is the arbiter itself.
interface sram_arbiter_if;
  // requester 0
  logic        R0_req;
  logic [17:0] R0_address;
  logic [15:0] R0_write_data;
  logic        R0_we_n;
  logic        R0_gnt;
  logic        R0_rvalid;

  // requester 1
  logic        R1_req;
  logic [17:0] R1_address;
  logic [15:0] R1_write_data;
  logic        R1_we_n;
  logic        R1_gnt;
  logic        R1_rvalid;

  // shared SRAM port and status
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_write_data;
  logic        SRAM_we_n;
  logic [15:0] SRAM_read_data;
  logic [15:0] Read_data;
  logic        Busy;

  modport master (
    output R0_req, R0_address, R0_write_data, R0_we_n,
    output R1_req, R1_address, R1_write_data, R1_we_n,
    output SRAM_read_data,
    input  R0_gnt, R0_rvalid, R1_gnt, R1_rvalid,
    input  SRAM_address, SRAM_write_data, SRAM_we_n, Read_data, Busy
  );

  modport slave (
    input  R0_req, R0_address, R0_write_data, R0_we_n,
    input  R1_req, R1_address, R1_write_data, R1_we_n,
    input  SRAM_read_data,
    output R0_gnt, R0_rvalid, R1_gnt, R1_rvalid,
    output SRAM_address, SRAM_write_data, SRAM_we_n, Read_data, Busy
  );
endinterface

// File: rtl/sram_arbiter.sv
// sram_arbiter: hands ownership of a single-port SRAM to one of two
// requesters for a whole burst, alternating on ties, and tags reads so the
// returning data can be attributed to the right port even after ownership
// has moved on.
//
// state  | meaning
// S_IDLE | no owner; SRAM port parked (read, address 0)
// S_OWN0 | port 0 owns the SRAM, its bus drives the SRAM port
// S_OWN1 | port 1 owns the SRAM, its bus drives the SRAM port
// S_TURN | one dead cycle after a release before the next grant
module sram_arbiter #(
  parameter int READ_LATENCY = 2
) (
  input logic           Clock,
  input logic           Resetn,
  sram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OWN0 = 2'd1,
    S_OWN1 = 2'd2,
    S_TURN = 2'd3
  } state_t;

  state_t state;
  logic   last_owner;
  logic   gnt0;
  logic   gnt1;

  // Read tag pipeline: entry 0 is the newest, the top entry lines up with
  // the SRAM returning data for that read.
  logic [READ_LATENCY-1:0] pipe_valid;
  logic [READ_LATENCY-1:0] pipe_port;
  logic                    read_issue;

  // Ownership FSM; grants are registered alongside the state so they are
  // glitch-free decodes of S_OWN0/S_OWN1. An owner is never preempted.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state      <= S_IDLE;
      last_owner <= 1'b1;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.R0_req && (!bus.R1_req || last_owner)) begin
            state <= S_OWN0;
            gnt0  <= 1'b1;
          end else if (bus.R1_req) begin
            state <= S_OWN1;
            gnt1  <= 1'b1;
          end
        end
        S_OWN0: begin
          if (!bus.R0_req) begin
            state      <= S_TURN;
            gnt0       <= 1'b0;
            last_owner <= 1'b0;
          end
        end
        S_OWN1: begin
          if (!bus.R1_req) begin
            state      <= S_TURN;
            gnt1       <= 1'b0;
            last_owner <= 1'b1;
          end
        end
        S_TURN: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          gnt0  <= 1'b0;
          gnt1  <= 1'b0;
        end
      endcase
    end
  end

  // A read is any owned cycle where the owner still requests with we_n high.
  assign read_issue = (gnt0 & bus.R0_req & bus.R0_we_n) |
                      (gnt1 & bus.R1_req & bus.R1_we_n);

  // Shift the {valid, port} tag of every read; runs regardless of state so
  // tail reads complete after the owner has released.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      pipe_valid <= '0;
      pipe_port  <= '0;
    end else begin
      pipe_valid[0] <= read_issue;
      pipe_port[0]  <= gnt1;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_port[i]  <= pipe_port[i-1];
      end
    end
  end

  // Route the owner's bus onto the SRAM; park it as a read of address 0
  // when nobody owns it. A releasing owner (req low) never writes.
  always_comb begin
    bus.SRAM_address    = '0;
    bus.SRAM_write_data = '0;
    bus.SRAM_we_n       = 1'b1;
    if (gnt0) begin
      bus.SRAM_address    = bus.R0_address;
      bus.SRAM_write_data = bus.R0_write_data;
      bus.SRAM_we_n       = bus.R0_we_n | ~bus.R0_req;
    end else if (gnt1) begin
      bus.SRAM_address    = bus.R1_address;
      bus.SRAM_write_data = bus.R1_write_data;
      bus.SRAM_we_n       = bus.R1_we_n | ~bus.R1_req;
    end
  end

  assign bus.R0_gnt    = gnt0;
  assign bus.R1_gnt    = gnt1;
  assign bus.R0_rvalid = pipe_valid[READ_LATENCY-1] & ~pipe_port[READ_LATENCY-1];
  assign bus.R1_rvalid = pipe_valid[READ_LATENCY-1] &  pipe_port[READ_LATENCY-1];
  assign bus.Read_data = bus.SRAM_read_data;
  assign bus.Busy      = (state != S_IDLE) | (|pipe_valid);

  gnt_exclusive: assert property (@(posedge Clock) disable iff (!Resetn)
    !(gnt0 && gnt1));

  rvalid_exclusive: assert property (@(posedge Clock) disable iff (!Resetn)
    !(bus.R0_rvalid && bus.R1_rvalid));

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed stimulus against a transaction-level model of
// the arbiter (owner/turn bookkeeping, a queue of pending reads with due
// cycles, and a shadow memory), plus literal spot checks on key cycles.
`timescale 1ns/1ps
module tb_sram_arbiter;
  localparam int LAT = 2;

  logic Clock = 1'b0;
  logic Resetn;

  sram_arbiter_if bus ();

  sram_arbiter #(.READ_LATENCY(LAT)) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (bus)
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // ---------------- SRAM device (2-cycle read latency) ----------------
  logic [15:0] sram_mem [int];
  logic [15:0] rd_stage1;
  logic [15:0] rd_stage2;
  assign bus.SRAM_read_data = rd_stage2;

  always @(posedge Clock) begin
    int a;
    a = int'(bus.SRAM_address);
    rd_stage2 <= rd_stage1;
    rd_stage1 <= sram_mem.exists(a) ? sram_mem[a] : 16'h0000;
    if (bus.SRAM_we_n == 1'b0) sram_mem[a] = bus.SRAM_write_data;
  end

  // ---------------- behavioural model ----------------
  typedef struct {
    int          due;
    logic        port;
    logic [15:0] data;
  } rd_t;

  rd_t         pend[$];
  logic [15:0] model_mem [int];
  int          owner      = -1;
  bit          in_turn    = 1'b0;
  int          last_owner = 1;
  int          cyc        = 0;

  function automatic logic req_of(input int p);
    return (p == 0) ? bus.R0_req : bus.R1_req;
  endfunction
  function automatic logic we_of(input int p);
    return (p == 0) ? bus.R0_we_n : bus.R1_we_n;
  endfunction
  function automatic logic [17:0] addr_of(input int p);
    return (p == 0) ? bus.R0_address : bus.R1_address;
  endfunction
  function automatic logic [15:0] wd_of(input int p);
    return (p == 0) ? bus.R0_write_data : bus.R1_write_data;
  endfunction

  always @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      owner      = -1;
      in_turn    = 1'b0;
      last_owner = 1;
      pend.delete();
    end else begin
      cyc++;
      while (pend.size() > 0 && pend[0].due < cyc) void'(pend.pop_front());
      if (owner >= 0 && req_of(owner)) begin
        int a;
        a = int'(addr_of(owner));
        if (we_of(owner)) begin
          pend.push_back('{cyc + LAT - 1, logic'(owner == 1),
                           model_mem.exists(a) ? model_mem[a] : 16'h0000});
        end else begin
          model_mem[a] = wd_of(owner);
        end
      end
      if (in_turn) begin
        in_turn = 1'b0;
      end else if (owner < 0) begin
        if (bus.R0_req && bus.R1_req) owner = 1 - last_owner;
        else if (bus.R0_req)          owner = 0;
        else if (bus.R1_req)          owner = 1;
      end else if (!req_of(owner)) begin
        last_owner = owner;
        owner      = -1;
        in_turn    = 1'b1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic        e_rv0, e_rv1, e_we;
  logic [15:0] e_rd, e_wd;
  logic [17:0] e_addr;
  logic        e_busy;

  always @(negedge Clock) begin
    e_rv0 = 1'b0; e_rv1 = 1'b0; e_rd = 16'h0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      if (pend[0].port) e_rv1 = 1'b1; else e_rv0 = 1'b1;
      e_rd = pend[0].data;
    end
    e_addr = '0; e_wd = '0; e_we = 1'b1;
    if (owner >= 0) begin
      e_addr = addr_of(owner);
      e_wd   = wd_of(owner);
      e_we   = we_of(owner) | ~req_of(owner);
    end
    e_busy = (owner >= 0) || in_turn || (pend.size() > 0);
    check("m_gnt0",   bus.R0_gnt,          owner == 0);
    check("m_gnt1",   bus.R1_gnt,          owner == 1);
    check("m_rvalid0", bus.R0_rvalid,      e_rv0);
    check("m_rvalid1", bus.R1_rvalid,      e_rv1);
    check("m_sram_we_n", bus.SRAM_we_n,    e_we);
    check("m_sram_addr", bus.SRAM_address, e_addr);
    check("m_sram_wd", bus.SRAM_write_data, e_wd);
    check("m_busy",   bus.Busy,            e_busy);
    if (e_rv0 || e_rv1) check("m_read_data", bus.Read_data, e_rd);
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(input int n = 1);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  initial begin
    Resetn            = 1'b0;
    bus.R0_req        = 1'b0; bus.R1_req        = 1'b0;
    bus.R0_we_n       = 1'b1; bus.R1_we_n       = 1'b1;
    bus.R0_address    = '0;   bus.R1_address    = '0;
    bus.R0_write_data = '0;   bus.R1_write_data = '0;
    tick(2);
    check("rst_gnt",    {bus.R1_gnt, bus.R0_gnt}, 2'b00);
    check("rst_rvalid", {bus.R1_rvalid, bus.R0_rvalid}, 2'b00);
    check("rst_we_n",   bus.SRAM_we_n, 1'b1);
    check("rst_addr",   bus.SRAM_address, 18'h0);
    check("rst_busy",   bus.Busy, 1'b0);
    Resetn = 1'b1;
    tick(2);

    // write 0xABCD to 0x00005, then read it back on port 0
    bus.R0_req = 1'b1; bus.R0_we_n = 1'b0;
    bus.R0_address = 18'h00005; bus.R0_write_data = 16'hABCD;
    tick();
    check("wr_gnt0",  bus.R0_gnt, 1'b1);
    check("wr_we_n",  bus.SRAM_we_n, 1'b0);
    check("wr_addr",  bus.SRAM_address, 18'h00005);
    check("wr_data",  bus.SRAM_write_data, 16'hABCD);
    tick();
    bus.R0_we_n = 1'b1;
    tick();
    check("rd_not_yet", bus.R0_rvalid, 1'b0);
    bus.R0_req = 1'b0;
    tick();
    check("rd_rvalid0", bus.R0_rvalid, 1'b1);
    check("rd_data",    bus.Read_data, 16'hABCD);
    check("rd_rvalid1", bus.R1_rvalid, 1'b0);
    tick(2);

    // reset pulse restores the tie-break, then a simultaneous request
    Resetn = 1'b0; #2; Resetn = 1'b1;
    bus.R0_req = 1'b1; bus.R0_we_n = 1'b1; bus.R0_address = 18'h00010;
    bus.R1_req = 1'b1; bus.R1_we_n = 1'b0; bus.R1_address = 18'h3FFFF;
    bus.R1_write_data = 16'h1234;
    tick();
    check("tie_gnt", {bus.R1_gnt, bus.R0_gnt}, 2'b01);
    tick();
    bus.R0_req = 1'b0;
    tick();
    check("turn_gnt",  {bus.R1_gnt, bus.R0_gnt}, 2'b00);
    check("turn_we_n", bus.SRAM_we_n, 1'b1);
    check("turn_busy", bus.Busy, 1'b1);
    tick();
    check("idle_gnt",  {bus.R1_gnt, bus.R0_gnt}, 2'b00);
    tick();
    check("handover_gnt", {bus.R1_gnt, bus.R0_gnt}, 2'b10);
    bus.R0_req = 1'b1;
    tick();
    check("no_preempt", {bus.R1_gnt, bus.R0_gnt}, 2'b10);
    bus.R1_we_n = 1'b1;
    tick();
    bus.R1_req = 1'b0;
    tick();
    check("tail_rvalid1", bus.R1_rvalid, 1'b1);
    check("tail_rvalid0", bus.R0_rvalid, 1'b0);
    check("tail_data",    bus.Read_data, 16'h1234);
    check("tail_busy",    bus.Busy, 1'b1);
    bus.R1_req = 1'b1;
    tick();
    check("tail_done_rv1", bus.R1_rvalid, 1'b0);
    check("tail_idle_busy", bus.Busy, 1'b0);
    tick();
    check("rr_gnt", {bus.R1_gnt, bus.R0_gnt}, 2'b01);
    tick(8);
    check("starve_gnt", {bus.R1_gnt, bus.R0_gnt}, 2'b01);
    bus.R0_req = 1'b0;
    tick(3);
    check("regrant_gnt1", bus.R1_gnt, 1'b1);
    bus.R1_address = 18'h00005;
    tick();

    // reset with port 1's read in flight
    bus.R1_req = 1'b0; bus.R0_req = 1'b0; Resetn = 1'b0;
    #1;
    check("midrst_gnt",    {bus.R1_gnt, bus.R0_gnt}, 2'b00);
    check("midrst_rvalid", {bus.R1_rvalid, bus.R0_rvalid}, 2'b00);
    check("midrst_busy",   bus.Busy, 1'b0);
    check("midrst_we_n",   bus.SRAM_we_n, 1'b1);
    tick();
    Resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_rvalid1", bus.R1_rvalid, 1'b0);
      check("post_rst_gnt1",    bus.R1_gnt, 1'b0);
    end
    bus.R1_req = 1'b1;
    tick();
    check("new_req_gnt1", bus.R1_gnt, 1'b1);
    bus.R1_req = 1'b0;
    tick(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
